// File: rtl/cache_pkg.sv
// Shared definitions for the cache port arbiter.
// Contents: default address/data widths, the arbiter FSM state encoding,
// and a helper that sizes the stall-wait counter from the timeout value.
package cache_pkg;

    localparam int unsigned AW_DEF      = 10;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Bits needed to count 0..t inclusive (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant logic.
// Ports:
//   i_req        {req1, req0} request levels
//   i_last_grant port that completed the most recent transaction
//   o_valid_c    at least one request present
//   o_grant_c    winning port index (0 or 1)
// With both ports requesting, RR=1 favours the port opposite i_last_grant,
// RR=0 always favours port 0. A lone requester always wins.
module rr_arb2 #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid_c,
    output logic       o_grant_c
);

    always_comb begin
        o_valid_c = |i_req;
        o_grant_c = 1'b0;
        if (i_req == 2'b11) begin
            o_grant_c = RR ? ~i_last_grant : 1'b0;
        end else begin
            o_grant_c = i_req[1];
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares a single-port cache between instruction fetch (port 0) and
// load/store (port 1). One request is granted at a time; its command is
// latched, driven into the cache for the whole transaction, and completed
// with a one-cycle ack once the cache stall is low.
// Ports:
//   clk, RST            clock, async active-low reset
//   reqN/weN/addrN/wdataN  requester command, held until ackN
//   ackN, rdataN        completion pulse, read data (held until next read ack)
//   RE, WE, A, DataIn   cache command (registered)
//   DataOut, stall      cache read data and busy indication
//   err                 sticky stall-timeout flag
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          RE,
    output logic          WE,
    output logic [AW-1:0] A,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut,
    input  logic          stall,
    output logic          err
);

    localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_cmd_we;
    logic             r_cmd_port;
    logic [AW-1:0]    r_cmd_addr;
    logic [DW-1:0]    r_cmd_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_ack0;
    logic             r_ack1;
    logic [DW-1:0]    r_rdata0;
    logic [DW-1:0]    r_rdata1;
    logic             r_re;
    logic             r_we;
    logic [AW-1:0]    r_a;
    logic [DW-1:0]    r_din;
    logic             r_err;

    logic             w_valid;
    logic             w_grant;

    rr_arb2 #(
        .RR (RR != 0)
    ) u_arb (
        .i_req        ({req1, req0}),
        .i_last_grant (r_last_grant),
        .o_valid_c    (w_valid),
        .o_grant_c    (w_grant)
    );

    // Arbiter FSM with command latch, stall counter and registered outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_cmd_we     <= 1'b0;
            r_cmd_port   <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_a          <= '0;
            r_din        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_cmd_port  <= w_grant;
                        r_cmd_we    <= w_grant ? we1    : we0;
                        r_cmd_addr  <= w_grant ? addr1  : addr0;
                        r_cmd_wdata <= w_grant ? wdata1 : wdata0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_re    <= ~r_cmd_we;
                    r_we    <= r_cmd_we;
                    r_a     <= r_cmd_addr;
                    r_din   <= r_cmd_wdata;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!stall) begin
                        if (!r_cmd_we) begin
                            if (r_cmd_port) r_rdata1 <= DataOut;
                            else            r_rdata0 <= DataOut;
                        end
                        if (r_cmd_port) r_ack1 <= 1'b1;
                        else            r_ack0 <= 1'b1;
                        r_re         <= 1'b0;
                        r_we         <= 1'b0;
                        r_last_grant <= r_cmd_port;
                        r_cnt        <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
                        // err rises on the edge where the count reaches TIMEOUT
                        if (r_cnt >= CNT_ERR) r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign RE     = r_re;
    assign WE     = r_we;
    assign A      = r_a;
    assign DataIn = r_din;
    assign err    = r_err;

endmodule
